// File: rtl/adc_snap_pkg.sv
// Shared types and constants for the quad-ADC snapshot capture controller.
package adc_snap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE_ST = 2'd3
  } state_t;

  localparam logic [1:0] MODE_IMM = 2'd0;
  localparam logic [1:0] MODE_EXT = 2'd1;
  localparam logic [1:0] MODE_LVL = 2'd2;

  localparam int SAMPLE_W = 10;
  localparam int CH_W     = 40;

endpackage

// File: rtl/adc_lvl_trig.sv
// Level trigger: flags any lane of a packed signed sample word that is strictly
// above the threshold. The OR result is registered.
module adc_lvl_trig
  import adc_snap_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                       clk_div_a,
  input  logic                       rst_n,
  input  logic [LANES*SAMPLE_W-1:0]  i_data,
  input  logic signed [SAMPLE_W-1:0] i_thresh,
  output logic                       o_hit
);

  logic [LANES-1:0] w_gt;
  logic             r_hit;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_gt[gi] = $signed(i_data[gi*SAMPLE_W +: SAMPLE_W]) > i_thresh;
  end

  always_ff @(posedge clk_div_a) begin
    if (!rst_n) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= |w_gt;
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/adc_snap_ctrl.sv
// Snapshot capture controller: on arm plus trigger, streams len consecutive
// 160-bit sample words into an external BRAM, then sets a sticky done flag.
module adc_snap_ctrl
  import adc_snap_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int SERDES_RATIO = 4
) (
  input  logic                             clk_div_a,
  input  logic                             rst_n,
  input  logic [SERDES_RATIO*SAMPLE_W-1:0] dataA_in,
  input  logic [SERDES_RATIO*SAMPLE_W-1:0] dataB_in,
  input  logic [SERDES_RATIO*SAMPLE_W-1:0] dataC_in,
  input  logic [SERDES_RATIO*SAMPLE_W-1:0] dataD_in,
  input  logic                             ext_trig,
  input  logic                             arm,
  input  logic                             abort,
  input  logic [ADDR_W-1:0]                cfg_len,
  input  logic [1:0]                       cfg_mode,
  input  logic signed [SAMPLE_W-1:0]       cfg_thresh,
  output logic                             bram_we,
  output logic [ADDR_W-1:0]                bram_addr,
  output logic [4*SERDES_RATIO*SAMPLE_W-1:0] bram_wdata,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      trig_cnt
);

  localparam int W = SERDES_RATIO * SAMPLE_W;
  localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};

  state_t                      r_state;
  logic                        r_arm_q;
  logic                        r_armed_q;
  logic                        r_ext_q;
  logic [4*W-1:0]              r_data_q;
  logic [ADDR_W:0]             r_len;
  logic [ADDR_W:0]             r_count;
  logic [1:0]                  r_mode;
  logic signed [SAMPLE_W-1:0]  r_thresh;
  logic                        r_we;
  logic [ADDR_W-1:0]           r_addr;
  logic [4*W-1:0]              r_wdata;
  logic                        r_busy;
  logic                        r_done;
  logic [15:0]                 r_trig_cnt;

  logic                        w_arm_rise;
  logic                        w_lvl_hit;
  logic                        w_trig_src;
  logic                        w_trig_q;
  logic [ADDR_W:0]             w_count_inc;
  logic [ADDR_W:0]             w_cfg_len;

  assign w_arm_rise  = arm & ~r_arm_q;
  assign w_count_inc = r_count + 1'b1;
  assign w_cfg_len   = (cfg_len == '0) ? FULL_LEN : {1'b0, cfg_len};

  adc_lvl_trig #(
    .LANES (SERDES_RATIO)
  ) u_lvl_trig (
    .clk_div_a (clk_div_a),
    .rst_n     (rst_n),
    .i_data    (dataA_in),
    .i_thresh  (r_thresh),
    .o_hit     (w_lvl_hit)
  );

  always_comb begin
    w_trig_src = 1'b1;
    case (r_mode)
      MODE_EXT: w_trig_src = r_ext_q;
      MODE_LVL: w_trig_src = w_lvl_hit;
      default:  w_trig_src = 1'b1;
    endcase
  end

  // Trigger qualifiers are only honoured for inputs sampled while ARMED, so the
  // first word written is the triggering word and never a pre-arm sample.
  assign w_trig_q = r_armed_q & w_trig_src;

  always_ff @(posedge clk_div_a) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_arm_q    <= 1'b0;
      r_armed_q  <= 1'b0;
      r_ext_q    <= 1'b0;
      r_data_q   <= '0;
      r_len      <= '0;
      r_count    <= '0;
      r_mode     <= MODE_IMM;
      r_thresh   <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_trig_cnt <= '0;
    end else begin
      r_arm_q   <= arm;
      r_ext_q   <= ext_trig;
      r_data_q  <= {dataD_in, dataB_in, dataC_in, dataA_in};
      r_armed_q <= (r_state == ARMED);
      r_we      <= 1'b0;

      case (r_state)
        IDLE: begin
          if (!abort && w_arm_rise) begin
            r_len    <= w_cfg_len;
            r_mode   <= cfg_mode;
            r_thresh <= cfg_thresh;
            r_done   <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= ARMED;
          end
        end

        ARMED: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_trig_q) begin
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_wdata <= r_data_q;
            r_count <= ONE_LEN;
            if (r_len == ONE_LEN) begin
              r_busy  <= 1'b0;
              r_state <= DONE_ST;
            end else begin
              r_state <= CAPTURE;
            end
          end
        end

        CAPTURE: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_we    <= 1'b1;
            r_addr  <= r_addr + 1'b1;
            r_wdata <= r_data_q;
            r_count <= w_count_inc;
            if (w_count_inc == r_len) begin
              r_busy  <= 1'b0;
              r_state <= DONE_ST;
            end
          end
        end

        DONE_ST: begin
          r_done     <= 1'b1;
          r_trig_cnt <= r_trig_cnt + 16'd1;
          r_state    <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bram_we    = r_we;
  assign bram_addr  = r_addr;
  assign bram_wdata = r_wdata;
  assign busy       = r_busy;
  assign done       = r_done;
  assign trig_cnt   = r_trig_cnt;

endmodule

// File: tb/tb_adc_snap_ctrl.sv
// Scoreboard bench for adc_snap_ctrl: stimulus pushes expected BRAM writes,
// a negedge monitor pops and compares every write the DUT issues.
module tb_adc_snap_ctrl;

  localparam int AW = 4;

  logic          clk_div_a = 1'b0;
  logic          rst_n;
  logic [39:0]   dataA_in, dataB_in, dataC_in, dataD_in;
  logic          ext_trig, arm, abort;
  logic [AW-1:0] cfg_len;
  logic [1:0]    cfg_mode;
  logic [9:0]    cfg_thresh;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [159:0]  bram_wdata;
  logic          busy, done;
  logic [15:0]   trig_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [AW+159:0] exp_q[$];

  adc_snap_ctrl #(.ADDR_W(AW), .SERDES_RATIO(4)) dut (
    .clk_div_a  (clk_div_a),
    .rst_n      (rst_n),
    .dataA_in   (dataA_in),
    .dataB_in   (dataB_in),
    .dataC_in   (dataC_in),
    .dataD_in   (dataD_in),
    .ext_trig   (ext_trig),
    .arm        (arm),
    .abort      (abort),
    .cfg_len    (cfg_len),
    .cfg_mode   (cfg_mode),
    .cfg_thresh (cfg_thresh),
    .bram_we    (bram_we),
    .bram_addr  (bram_addr),
    .bram_wdata (bram_wdata),
    .busy       (busy),
    .done       (done),
    .trig_cnt   (trig_cnt)
  );

  always #5 clk_div_a = ~clk_div_a;

  // Ramp pattern: every channel carries the cycle number under a channel tag.
  function automatic logic [159:0] word(input int n);
    logic [31:0] v;
    v = n;
    word = {8'hD0, v, 8'hB0, v, 8'hC0, v, 8'hA0, v};
  endfunction

  function automatic logic [39:0] lanes(input logic [9:0] l3, l2, l1, l0);
    lanes = {l3, l2, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk_div_a);
    #1;
    cyc++;
    {dataD_in, dataB_in, dataC_in, dataA_in} = word(cyc);
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic push(input int addr, input logic [159:0] data);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    exp_q.push_back({a, data});
  endtask

  task automatic wait_done(input int maxc, input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < maxc) begin
      tick();
      n++;
    end
    if (done !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: done not seen within %0d cycles", name, maxc);
    end
  endtask

  task automatic start(input logic [1:0] mode, input logic [AW-1:0] len, input logic [9:0] th);
    cfg_mode   = mode;
    cfg_len    = len;
    cfg_thresh = th;
    arm        = 1'b1;
  endtask

  always @(negedge clk_div_a) begin
    logic [AW+159:0] e;
    if (bram_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %0h, want no write", bram_addr, bram_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bram_addr, bram_wdata} !== e) begin
          miscompares++;
          $display("FAIL bram_write: got addr %0d data %0h, want addr %0d data %0h",
                   bram_addr, bram_wdata, e[AW+159:160], e[159:0]);
        end else begin
          $display("ok   write addr %0d data %0h", bram_addr, bram_wdata);
        end
      end
    end
  end

  initial begin
    int k;
    rst_n = 1'b0; ext_trig = 1'b0; arm = 1'b0; abort = 1'b0;
    cfg_len = '0; cfg_mode = 2'd0; cfg_thresh = '0;
    {dataD_in, dataB_in, dataC_in, dataA_in} = word(0);
    repeat (3) tick();
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_wdata", bram_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_trig_cnt", trig_cnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Mode 0, length 8: words k+1..k+8 land at addresses 0..7.
    k = cyc;
    start(2'd0, 4'd8, 10'd0);
    for (int i = 0; i < 8; i++) push(i, word(k + 1 + i));
    tick();
    arm = 1'b0;
    chk("m0_busy", busy, 1);
    wait_done(30, "m0_done");
    chk("m0_done", done, 1);
    chk("m0_busy_end", busy, 0);
    chk("m0_trig_cnt", trig_cnt, 1);
    chk("m0_drained", exp_q.size(), 0);
    repeat (2) tick();

    // Mode 2, threshold +100: equal and negative samples must not trigger.
    k = cyc;
    start(2'd2, 4'd2, 10'd100);
    dataA_in = lanes(10'd100, 10'h338, 10'd0, 10'h3FF);
    tick();
    arm = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) tick();
      dataA_in = lanes(10'h3FF, 10'd100, 10'(i), 10'd100);
    end
    tick();
    dataA_in = lanes(10'd0, 10'd101, 10'd0, 10'd0);
    push(0, {dataD_in, dataB_in, dataC_in, dataA_in});
    tick();
    dataA_in = lanes(10'd100, 10'h338, 10'd22, 10'h3FF);
    push(1, {dataD_in, dataB_in, dataC_in, dataA_in});
    chk("m2_busy_wait", busy, 1);
    wait_done(20, "m2_done");
    chk("m2_trig_cnt", trig_cnt, 2);
    chk("m2_drained", exp_q.size(), 0);
    repeat (2) tick();

    // Mode 1, length 0 -> full 16-word depth, addresses 0..15 with no wrap.
    k = cyc;
    start(2'd1, 4'd0, 10'd0);
    tick();
    arm = 1'b0;
    repeat (3) tick();
    ext_trig = 1'b1;
    for (int i = 0; i < 16; i++) push(i, word(k + 4 + i));
    tick();
    ext_trig = 1'b0;
    wait_done(40, "m1_done");
    chk("m1_trig_cnt", trig_cnt, 3);
    chk("m1_drained", exp_q.size(), 0);
    repeat (3) tick();
    chk("m1_no_more", exp_q.size(), 0);

    // Abort during the third write cycle: only three writes, done stays low.
    k = cyc;
    start(2'd0, 4'd8, 10'd0);
    for (int i = 0; i < 3; i++) push(i, word(k + 1 + i));
    tick();
    arm = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_we", bram_we, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    chk("ab_trig_cnt", trig_cnt, 3);
    chk("ab_drained", exp_q.size(), 0);
    repeat (4) tick();

    // Arm pulse during capture and arm held after done must not re-arm.
    k = cyc;
    start(2'd0, 4'd8, 10'd0);
    for (int i = 0; i < 8; i++) push(i, word(k + 1 + i));
    tick();
    arm = 1'b0;
    repeat (2) tick();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    arm = 1'b1;
    wait_done(30, "hold_done");
    repeat (6) tick();
    chk("hold_busy", busy, 0);
    chk("hold_done", done, 1);
    chk("hold_trig_cnt", trig_cnt, 4);
    chk("hold_drained", exp_q.size(), 0);
    arm = 1'b0;
    tick();

    // Fresh edge re-arms and clears done; reserved mode 3 acts as immediate, len 1.
    k = cyc;
    start(2'd3, 4'd1, 10'd0);
    push(0, word(k + 1));
    tick();
    arm = 1'b0;
    chk("rearm_done_clr", done, 0);
    chk("rearm_busy", busy, 1);
    wait_done(10, "len1_done");
    chk("len1_trig_cnt", trig_cnt, 5);
    chk("len1_drained", exp_q.size(), 0);
    repeat (2) tick();

    // One-cycle reset mid-capture abandons the capture.
    k = cyc;
    start(2'd0, 4'd8, 10'd0);
    for (int i = 0; i < 3; i++) push(i, word(k + 1 + i));
    tick();
    arm = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_we", bram_we, 0);
    chk("mrst_addr", bram_addr, 0);
    chk("mrst_wdata", bram_wdata, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_trig_cnt", trig_cnt, 0);
    repeat (12) tick();
    chk("mrst_idle_busy", busy, 0);
    chk("mrst_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
